// File: rtl/ariane_pkg.sv
// Shared types for the branch-prediction path.
// bht_update_t: one update beat toward the branch history table.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

endpackage

// File: rtl/bht_update_queue.sv
// Buffers resolved branches (two lanes/cycle) and drains one BHT update per cycle.
// Ports: clk_i, rst_ni (async low), flush_i, debug_mode_i, res_* lanes in,
//        res_ready_o, bht_update_o, resolved_cnt_o, mispredict_cnt_o.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             debug_mode_i,
    input  logic [1:0]       res_valid_i,
    output logic             res_ready_o,
    input  logic [1:0][63:0] res_pc_i,
    input  logic [1:0]       res_taken_i,
    input  logic [1:0]       res_pred_taken_i,
    output bht_update_t      bht_update_o,
    output logic [31:0]      resolved_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [63:0]    pc_mem [DEPTH];
    logic [DEPTH-1:0] tk_mem;

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  wptr_l1;
    logic [PW:0]    cnt_q, cnt_d;
    logic [31:0]    res_cnt_q, res_cnt_d;
    logic [31:0]    mis_cnt_q, mis_cnt_d;

    logic [1:0]     acc;
    logic [1:0]     mis;
    logic [1:0]     n_acc;
    logic [1:0]     n_mis;
    logic           pop;

    // Adds 0..2 and clamps at all-ones; the carry bit catches a +2 overflow.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [1:0]  inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Two free slots are required so both lanes can always land.
    assign res_ready_o = (cnt_q <= (PW+1)'(DEPTH - 2));

    always_comb begin
        acc   = res_valid_i & {2{res_ready_o & ~debug_mode_i & ~flush_i}};
        mis   = acc & (res_taken_i ^ res_pred_taken_i);
        n_acc = {1'b0, acc[0]} + {1'b0, acc[1]};
        n_mis = {1'b0, mis[0]} + {1'b0, mis[1]};
        pop   = (cnt_q != '0) & ~flush_i;
        // Lane 1 packs behind lane 0 only if lane 0 was taken in.
        wptr_l1 = wptr_q + PW'(acc[0]);
    end

    always_comb begin
        wptr_d    = wptr_q + PW'(n_acc);
        rptr_d    = rptr_q + PW'(pop);
        cnt_d     = cnt_q + (PW+1)'(n_acc) - (PW+1)'(pop);
        res_cnt_d = sat_add(res_cnt_q, n_acc);
        mis_cnt_d = sat_add(mis_cnt_q, n_mis);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            res_cnt_q <= res_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Payload storage is not reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (acc[0]) begin
            pc_mem[wptr_q] <= res_pc_i[0];
            tk_mem[wptr_q] <= res_taken_i[0];
        end
        if (acc[1]) begin
            pc_mem[wptr_l1] <= res_pc_i[1];
            tk_mem[wptr_l1] <= res_taken_i[1];
        end
    end

    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = (cnt_q != '0);
        if (cnt_q != '0) begin
            bht_update_o.pc    = pc_mem[rptr_q];
            bht_update_o.taken = tk_mem[rptr_q];
        end
    end

    assign resolved_cnt_o   = res_cnt_q;
    assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue with a queue-based reference model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_bht_update_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 8;
    localparam longint unsigned MAXC = 64'hFFFF_FFFF;

    logic             clk;
    logic             rst_ni;
    logic             flush_i;
    logic             debug_mode_i;
    logic [1:0]       res_valid_i;
    logic             res_ready_o;
    logic [1:0][63:0] res_pc_i;
    logic [1:0]       res_taken_i;
    logic [1:0]       res_pred_taken_i;
    bht_update_t      upd;
    logic [31:0]      resolved_cnt_o;
    logic [31:0]      mispredict_cnt_o;

    bht_update_queue #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .res_valid_i     (res_valid_i),
        .res_ready_o     (res_ready_o),
        .res_pc_i        (res_pc_i),
        .res_taken_i     (res_taken_i),
        .res_pred_taken_i(res_pred_taken_i),
        .bht_update_o    (upd),
        .resolved_cnt_o  (resolved_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    typedef struct {
        logic [63:0] pc;
        logic        tk;
    } ent_t;

    ent_t            sb[$];
    longint unsigned m_res;
    longint unsigned m_mis;
    int              vec;
    int              err;
    bit              mon_en;
    bit              last_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned a,
                                            input int n);
        longint unsigned s;
        s = a + longint'(n);
        return (s > MAXC) ? MAXC : s;
    endfunction

    // Monitor: the table consumes the head every non-flush cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready", 64'(res_ready_o), 64'(sb.size() <= DEPTH - 2));
            chk("valid", 64'(upd.valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("pc", upd.pc, sb[0].pc);
                chk("taken", 64'(upd.taken), 64'(sb[0].tk));
                if (!flush_i) void'(sb.pop_front());
            end else begin
                chk("pc_idle", upd.pc, 64'd0);
                chk("taken_idle", 64'(upd.taken), 64'd0);
            end
            chk("resolved_cnt", 64'(resolved_cnt_o), m_res);
            chk("mispredict_cnt", 64'(mispredict_cnt_o), m_mis);
        end
    end

    task automatic cycle(input logic [1:0] v, input logic [63:0] pc0,
                         input logic [63:0] pc1, input logic [1:0] tk,
                         input logic [1:0] pr, input logic dbg,
                         input logic fl);
        bit   rdy;
        int   na;
        int   nm;
        ent_t e;
        res_valid_i      = v;
        res_pc_i[0]      = pc0;
        res_pc_i[1]      = pc1;
        res_taken_i      = tk;
        res_pred_taken_i = pr;
        debug_mode_i     = dbg;
        flush_i          = fl;
        rdy        = (sb.size() <= DEPTH - 2);
        last_ready = rdy;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else if (rdy && !dbg) begin
            na = 0;
            nm = 0;
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    e.pc = (i == 0) ? pc0 : pc1;
                    e.tk = tk[i];
                    sb.push_back(e);
                    na++;
                    if (tk[i] != pr[i]) nm++;
                end
            end
            m_res = sat(m_res, na);
            m_mis = sat(m_mis, nm);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [1:0]  v;
        logic [63:0] p0;
        logic [63:0] p1;
        logic [1:0]  tk;
        logic [1:0]  pr;
        logic        dbg;
        logic        fl;
        vec = 0;
        err = 0;
        mon_en = 0;
        m_res = 0;
        m_mis = 0;
        rst_ni = 0;
        flush_i = 0;
        debug_mode_i = 0;
        res_valid_i = 0;
        res_pc_i = '0;
        res_taken_i = 0;
        res_pred_taken_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(res_ready_o), 64'd1);
        chk("rst_valid", 64'(upd.valid), 64'd0);
        chk("rst_pc", upd.pc, 64'd0);
        chk("rst_res", 64'(resolved_cnt_o), 64'd0);
        chk("rst_mis", 64'(mispredict_cnt_o), 64'd0);
        rst_ni = 1;
        mon_en = 1;

        // single branch into an empty queue
        cycle(2'b01, 64'h8000_0010, 0, 2'b01, 2'b00, 0, 0);
        chk("single_valid", 64'(upd.valid), 64'd1);
        chk("single_pc", upd.pc, 64'h8000_0010);
        chk("single_res", 64'(resolved_cnt_o), 64'd1);
        idle(2);

        // dual issue
        cycle(2'b11, 64'h100, 64'h104, 2'b10, 2'b10, 0, 0);
        chk("dual_pc0", upd.pc, 64'h100);
        idle(1);
        chk("dual_pc1", upd.pc, 64'h104);
        idle(2);

        // fill and backpressure with the producer holding lanes
        p0 = 64'h1000;
        for (int i = 0; i < 24; i++) begin
            cycle(2'b11, p0, p0 + 4, 2'b01, 2'b00, 0, 0);
            if (last_ready) p0 = p0 + 8;
        end
        idle(10);

        // flush with five entries queued
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 64'h2000 + 64'(i * 8), 64'h2004 + 64'(i * 8),
                  2'b11, 2'b00, 0, 0);
        chk("pre_flush_occ", 64'(dut.cnt_q), 64'd5);
        cycle(2'b11, 64'h3000, 64'h3004, 2'b11, 2'b00, 0, 1);
        chk("flush_valid", 64'(upd.valid), 64'd0);
        idle(2);

        // debug mode drops lanes but queue still drains
        cycle(2'b11, 64'h4000, 64'h4004, 2'b00, 2'b11, 0, 0);
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 64'h5000, 64'h5004, 2'b11, 2'b00, 1, 0);
        idle(2);

        // asynchronous reset mid-operation
        cycle(2'b11, 64'h6000, 64'h6004, 2'b01, 2'b10, 0, 0);
        cycle(2'b11, 64'h6008, 64'h600c, 2'b01, 2'b10, 0, 0);
        res_valid_i = 0;
        #1;
        mon_en = 0;
        rst_ni = 0;
        #1;
        chk("arst_valid", 64'(upd.valid), 64'd0);
        chk("arst_ready", 64'(res_ready_o), 64'd1);
        chk("arst_res", 64'(resolved_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1;
        sb.delete();
        m_res = 0;
        m_mis = 0;
        mon_en = 1;
        idle(1);

        // counter saturation
        force dut.res_cnt_q = 32'hFFFF_FFFE;
        force dut.mis_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.res_cnt_q;
        release dut.mis_cnt_q;
        m_res = 64'hFFFF_FFFE;
        m_mis = 64'hFFFF_FFFE;
        cycle(2'b11, 64'h7000, 64'h7004, 2'b11, 2'b00, 0, 0);
        chk("sat_res", 64'(resolved_cnt_o), 64'hFFFF_FFFF);
        chk("sat_mis", 64'(mispredict_cnt_o), 64'hFFFF_FFFF);
        cycle(2'b11, 64'h7008, 64'h700c, 2'b11, 2'b00, 0, 0);
        chk("sat_hold", 64'(resolved_cnt_o), 64'hFFFF_FFFF);
        idle(4);

        // randomized traffic; lanes are held while not ready
        v  = 0;
        p0 = 0;
        p1 = 0;
        tk = 0;
        pr = 0;
        for (int i = 0; i < 400; i++) begin
            if (last_ready || v == 2'b00) begin
                v  = 2'($urandom_range(0, 3));
                p0 = {$urandom, $urandom};
                p1 = {$urandom, $urandom};
                tk = 2'($urandom_range(0, 3));
                pr = 2'($urandom_range(0, 3));
            end
            dbg = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            cycle(v, p0, p1, tk, pr, dbg, fl);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of buffered update entries; legal values are powers of two, 4 or greater.
REQ-002 clk_i  input  1  SHALL be the single clock; every register is updated on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 flush_i  input  1  SHALL, when high, discard all queued updates.
REQ-005 debug_mode_i  input  1  SHALL, when high, cause resolved branches to be dropped at the input.
REQ-006 res_valid_i  input  2  SHALL carry one valid bit per resolved-branch lane (lane 0 is older).
REQ-007 res_ready_o  output  1  SHALL indicate that both lanes can be accepted this cycle.
REQ-008 res_pc_i  input  2x64  SHALL carry the branch PC per lane.
REQ-009 res_taken_i  input  2  SHALL carry the actual outcome per lane.
REQ-010 res_pred_taken_i  input  2  SHALL carry the predicted outcome per lane.
REQ-011 bht_update_o  output  ariane_pkg::bht_update_t  SHALL drive the branch history table update (valid, pc, taken).
REQ-012 resolved_cnt_o  output  32  SHALL report the count of accepted resolved branches.
REQ-013 mispredict_cnt_o  output  32  SHALL report the count of accepted mispredicted branches.

Function
REQ-014 The block SHALL be a circular FIFO with a write pointer, a read pointer (log2(DEPTH) bits each, wrapping modulo DEPTH) and an occupancy count (log2(DEPTH)+1 bits).
REQ-015 res_ready_o SHALL be high when the occupancy is at most DEPTH-2; it is driven from registered state only and does not depend on any input in the same cycle.
REQ-016 A lane SHALL be accepted in a cycle only when res_valid_i[lane], res_ready_o, !debug_mode_i and !flush_i are all high; lanes offered while res_ready_o is low are not accepted, and the producer holds them.
REQ-017 Accepted lanes SHALL be written in lane order: lane 0 at wptr, then lane 1 at wptr+1, or at wptr if lane 0 is invalid; wptr advances by the number of accepted lanes.
REQ-018 bht_update_o.valid SHALL equal (occupancy != 0); pc and taken SHALL come from the entry at rptr; with occupancy 0, pc and taken are 0.
REQ-019 Whenever the occupancy is non-zero and flush_i is low, the head entry SHALL be popped every cycle, because the table accepts one update per cycle without backpressure.
REQ-020 Latency: an entry accepted in cycle N SHALL appear on bht_update_o no earlier than cycle N+1; with an empty queue it appears in exactly N+1.
REQ-021 Simultaneous push and pop SHALL be legal: occupancy_next = occupancy + accepted - popped.
REQ-022 In a flush_i cycle: rptr, wptr and occupancy SHALL return to 0 on the next edge; no lane is accepted; the statistics counters are unchanged.
REQ-023 resolved_cnt_o SHALL increase by the number of accepted lanes (0, 1 or 2) and SHALL saturate at 32'hFFFF_FFFF.
REQ-024 mispredict_cnt_o SHALL increase by the number of accepted lanes where taken != pred_taken and SHALL saturate at 32'hFFFF_FFFF, including when a +2 increment would overflow.
REQ-025 Storage entries SHALL hold only pc[63:0] and taken; entries are not cleared on pop.

Reset
REQ-026 While rst_ni is low: rptr, wptr and occupancy SHALL be 0; bht_update_o SHALL be all zeros; res_ready_o SHALL be 1; both counters SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-028 Storage array contents need not be reset.

Verification
REQ-029 Single branch, empty queue: lane 0 with pc=0x8000_0010, taken=1, pred=0 -> next cycle bht_update_o = {1, 0x8000_0010, 1}; resolved_cnt=1, mispredict_cnt=1.
REQ-030 Dual issue: lane 0 pc=0x100 taken=0, lane 1 pc=0x104 taken=1 -> 0x100 then 0x104 on consecutive cycles; resolved_cnt=2.
REQ-031 Fill and backpressure, DEPTH=8: both lanes valid every cycle -> occupancy rises by 1 per cycle until it reaches 7; from then on res_ready_o is low on alternating cycles; the output sequence is in order with no loss or duplication; pointers wrap correctly.
REQ-032 Flush with 5 entries queued and both lanes valid -> next cycle bht_update_o.valid=0, occupancy 0, counters unchanged.
REQ-033 debug_mode_i=1 with lanes valid -> nothing is queued and counters do not move; previously queued entries still drain.
REQ-034 Counter saturation: resolved_cnt forced to 0xFFFF_FFFE, then two lanes accepted -> counter reads 0xFFFF_FFFF and holds there.
